bin_tape_loader: RTL

- Hardware replacement for front-panel deposit loading of PDP-8 programs.
- Consumes a PAL BIN-format frame stream (leader, origin, data, checksum, trailer) and assembles 12-bit words.
- Writes each data word into main memory over the memory bus write handshake, verifies the tape checksum, then reports done and the start address.
- Sits upstream of Top/memory; the CPU is held idle until load_done.

---
 rtl/bin_tape_loader_pkg.sv | 16 +
 rtl/bin_frame_decoder.sv | 17 +
 rtl/bin_tape_loader.sv | 109 ++++++++++
 3 files changed

// File: rtl/bin_tape_loader_pkg.sv
// bin_tape_loader_pkg: shared loader state encoding and PAL BIN frame constants
package bin_tape_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEADER,
    S_HIGH,
    S_LOW,
    S_WRITE,
    S_FINISH,
    S_DONE
  } loader_state_t;
  localparam logic [7:0] LEADER_FRAME = 8'o200;
  localparam logic [7:0] RUBOUT_FRAME = 8'o377;
  localparam logic [7:0] FIELD_MASK   = 8'o300;
  localparam int         ORIGIN_BIT   = 6;
endpackage

// File: rtl/bin_frame_decoder.sv
// bin_frame_decoder: classifies one BIN tape frame (frame in; is_leader/is_origin/is_field/is_rubout/payload out)
module bin_frame_decoder
  import bin_tape_loader_pkg::*;
(
  input  logic [7:0] frame,
  output logic       is_leader,
  output logic       is_origin,
  output logic       is_field,
  output logic       is_rubout,
  output logic [5:0] payload
);
  assign is_rubout = frame == RUBOUT_FRAME;
  assign is_field  = !is_rubout && (frame & FIELD_MASK) == FIELD_MASK;
  assign is_leader = (frame & FIELD_MASK) == LEADER_FRAME;
  assign is_origin = !frame[7] && frame[ORIGIN_BIT];
  assign payload   = frame[5:0];
endmodule

// File: rtl/bin_tape_loader.sv
// bin_tape_loader: BIN tape frames in, 12-bit memory writes out (start/in_*/mem_* handshakes, busy/load_done/checksum_ok/word_count/start_pc status)
module bin_tape_loader
  import bin_tape_loader_pkg::*;
#(
  parameter logic [11:0] DEFAULT_ORIGIN = 12'o0200,
  parameter logic [11:0] START_PC       = 12'o0200
) (
  input  logic        clk,
  input  logic        btnCpuReset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_frame,
  output logic        in_ready,
  output logic        mem_write_enable,
  output logic [11:0] mem_address,
  output logic [11:0] mem_write_data,
  input  logic        mem_finished,
  output logic        busy,
  output logic        load_done,
  output logic        checksum_ok,
  output logic [11:0] word_count,
  output logic [11:0] start_pc
);
  loader_state_t state, nxt;
  logic        is_leader, is_origin, is_field, is_rubout;
  logic [5:0]  payload;
  logic [6:0]  hi;
  logic [11:0] pend_word, addr, wdata, sum, wcnt;
  logic [7:0]  pend_fs;
  logic        pend_org, pend_valid, ok;
  logic        accept, useful, take, take_hi, take_lo, launch;
  bin_frame_decoder u_dec (
    .frame     (in_frame),
    .is_leader (is_leader),
    .is_origin (is_origin),
    .is_field  (is_field),
    .is_rubout (is_rubout),
    .payload   (payload)
  );
  assign in_ready = state == S_LEADER || state == S_HIGH || state == S_LOW;
  assign accept   = in_valid && in_ready;
  assign useful   = accept && !is_rubout && !is_field;
  assign take     = useful && !is_leader;
  assign take_hi  = take && (state == S_LEADER || state == S_HIGH);
  assign take_lo  = take && state == S_LOW;
  assign launch   = start && (state == S_IDLE || state == S_DONE);
  // The commit of the parked word happens on the edge that accepts the low
  // frame, so the write request appears in the very next cycle.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_DONE: nxt = start ? S_LEADER : state;
      S_LEADER:       nxt = take ? S_LOW : state;
      S_HIGH:         nxt = useful ? (is_leader ? S_FINISH : S_LOW) : state;
      S_LOW:          nxt = useful ? (is_leader ? S_DONE : (pend_valid && !pend_org ? S_WRITE : S_HIGH)) : state;
      S_WRITE:        nxt = mem_finished ? S_HIGH : state;
      S_FINISH:       nxt = S_DONE;
      default:        nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge btnCpuReset)
    if (!btnCpuReset) begin
      state      <= S_IDLE;
      hi         <= '0;
      pend_word  <= '0;
      pend_fs    <= '0;
      pend_org   <= 1'b0;
      pend_valid <= 1'b0;
      addr       <= DEFAULT_ORIGIN;
      wdata      <= '0;
      sum        <= '0;
      wcnt       <= '0;
      ok         <= 1'b0;
    end else begin
      state <= nxt;
      if (launch) begin
        addr       <= DEFAULT_ORIGIN;
        sum        <= '0;
        wcnt       <= '0;
        pend_valid <= 1'b0;
        ok         <= 1'b0;
      end
      if (take_hi) hi <= {is_origin, payload};
      if (take_lo) begin
        pend_word  <= {hi[5:0], payload};
        pend_org   <= hi[6];
        pend_fs    <= {1'b0, hi} + {1'b0, in_frame[6:0]};
        pend_valid <= 1'b1;
        if (pend_valid) begin
          sum <= sum + {4'b0, pend_fs};
          if (pend_org) addr <= pend_word;
          else begin
            wdata <= pend_word;
            wcnt  <= wcnt + 12'd1;
          end
        end
      end
      if (state == S_WRITE && mem_finished) addr <= addr + 12'd1;
      if (state == S_FINISH) ok <= pend_valid && pend_word == sum;
    end
  assign mem_write_enable = state == S_WRITE;
  assign mem_address      = mem_write_enable ? addr : '0;
  assign mem_write_data   = mem_write_enable ? wdata : '0;
  assign busy             = !(state == S_IDLE || state == S_DONE);
  assign load_done        = state == S_DONE;
  assign checksum_ok      = load_done && ok;
  assign word_count       = wcnt;
  assign start_pc         = load_done ? START_PC : '0;
endmodule
